uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO in front of a UART transmitter. Bytes written on `wr` are queued
// in a circular buffer. A small handoff FSM pops one byte into `din` and
// pulses `tx_start` for one cycle. It then waits for the transmitter's
// `tx_done_tick` before it offers the next byte.
//
// Handshake: a write is accepted on any rising edge where wr=1 and full=0.
// A write while full is dropped. The transmitter must treat tx_start as a
// one-cycle request that is qualified by nothing else. It acknowledges the
// frame by pulsing tx_done_tick once, at the end of the stop bit. A done
// pulse arriving outside WAIT is ignored.
//
// Parameters
//   DBIT    data byte width (default 8)
//   ADDR_W  FIFO address width; depth = 2**ADDR_W (default 4 -> 16)
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   wr            write strobe, one byte per cycle while high
//   w_data        byte to enqueue
//   tx_done_tick  end-of-frame pulse from the transmitter
//   tx_start      registered one-cycle start request (high only in LOAD)
//   din           registered byte for the transmitter, changes only on load
//   full / empty  FIFO occupancy flags
//   level         bytes stored, excluding the byte in flight
//   busy          high while a frame is handed off and not yet done
//   dbg_state_o   FSM state for debug/observation (0=IDLE, 1=LOAD, 2=WAIT)
//
// Optional feature (macro UART_TX_FIFO_OVF_EN)
//   ovf      sticky flag, set by any dropped write
//   ovf_clr  clears ovf; a drop in the same cycle wins
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DBIT-1:0]   w_data,
    input  logic              tx_done_tick,
`ifdef UART_TX_FIFO_OVF_EN
    input  logic              ovf_clr,
    output logic              ovf,
`endif
    output logic              tx_start,
    output logic [DBIT-1:0]   din,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    localparam int               DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DBIT-1:0]     mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic [DBIT-1:0]     din_q, din_d;
    logic                tx_start_q, tx_start_d;
    logic                push;
    logic                pop;

    // Flags come from the registered level. A write and a pop in the same
    // cycle therefore both see the pre-pop occupancy, so a write to a full
    // FIFO is dropped even when a pop happens on that edge.
    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);
    assign push  = wr && !full;
    assign pop   = (state_q == IDLE) && !empty;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        din_d      = din_q;
        tx_start_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d    = LOAD;
                    din_d      = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    // Registering the start pulse on entry to LOAD makes
                    // tx_start_q high exactly while the FSM is in LOAD.
                    tx_start_d = 1'b1;
                end
            end
            LOAD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            din_q      <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            din_q      <= din_d;
            tx_start_q <= tx_start_d;
        end
    end

    // Storage is not reset. The pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr && full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`endif

    assign tx_start    = tx_start_q;
    assign din         = din_q;
    assign level       = level_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Bench for uart_tx_fifo. A table of single-cycle vectors covers reset and
// the basic handoff timing. Hand-written sequences cover fill/overflow/drain,
// pointer wrap under simultaneous write+pop, and reset during a frame.
// Accepted bytes go into exp_q. Every tx_start pops exp_q and the popped
// byte must match din.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic       tx_start;
    logic [7:0] din;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       busy;
    logic [1:0] dbg_state;
`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf_clr = 1'b0;
    logic       ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_starts = 0;
    logic       prev_start = 1'b0;
    logic [7:0] prev_din = 8'h00;
    logic [7:0] exp_q[$];

    uart_tx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .w_data       (w_data),
        .tx_done_tick (tx_done_tick),
`ifdef UART_TX_FIFO_OVF_EN
        .ovf_clr      (ovf_clr),
        .ovf          (ovf),
`endif
        .tx_start     (tx_start),
        .din          (din),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .busy         (busy),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver + scoreboard ----------------
    // One clock cycle: drive inputs, update the model at the edge, then sample
    // outputs 1 time unit later.
    task automatic tick(input logic r, input logic w, input logic [7:0] d, input logic done);
        logic [7:0] e;
        reset = r; wr = w; w_data = d; tx_done_tick = done;
        @(posedge clk);
        // Occupancy before this edge decides acceptance (full wins over pop).
        if (r) exp_q.delete();
        else if (w && exp_q.size() < DEPTH) exp_q.push_back(d);
        #1;
        if (tx_start) begin
            n_starts++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_start", 32'(tx_start), 32'(1'b0));
            end else begin
                e = exp_q.pop_front();
                check("sb_din", 32'(din), 32'(e));
            end
        end
        check("start_one_cycle", 32'(tx_start && prev_start), 32'(1'b0));
        if (!r && !tx_start) check("din_stable", 32'(din), 32'(prev_din));
        check("level_model", 32'(level), 32'(exp_q.size()));
        check("empty_model", 32'(empty), 32'(exp_q.size() == 0));
        check("full_model",  32'(full),  32'(exp_q.size() == DEPTH));
        prev_start = tx_start;
        prev_din   = din;
        reset = 1'b0; wr = 1'b0; tx_done_tick = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b0;
`endif
    endtask

    // Ends the frame in flight. The FSM must then spend a cycle in IDLE.
    task automatic finish_frame();
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("idle_gap_busy",  32'(busy),     32'(1'b0));
        check("idle_gap_start", 32'(tx_start), 32'(1'b0));
    endtask

    // Bounded wait for the next tx_start, then one cycle into WAIT.
    task automatic next_frame();
        int i;
        i = 0;
        while (!tx_start && i < 4) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0);
            i++;
        end
        check("start_seen", 32'(tx_start), 32'(1'b1));
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        check("wait_busy", 32'(busy), 32'(1'b1));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       done;
        logic       exp_start;
        logic       exp_busy;
        logic [4:0] exp_level;
        logic       exp_empty;
        logic [7:0] exp_din;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int starts0;

        //            wr    data   done  start busy  level  empty din
        vecs[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00}; // write to empty
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 8'h55}; // start 2 cycles after wr
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 8'h55}; // WAIT
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 8'h55}; // still WAIT
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'h55}; // done -> IDLE
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'h55}; // done in IDLE ignored
        vecs[6]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'h55};
        vecs[7]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 8'h33}; // pop + write, level holds
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 8'h33}; // done in LOAD ignored
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 8'h33}; // done in WAIT
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 8'h44}; // after one IDLE cycle
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 8'h44};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'h44};

        // ---- reset state ----
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_tx_start", 32'(tx_start),  32'(1'b0));
        check("rst_busy",     32'(busy),      32'(1'b0));
        check("rst_din",      32'(din),       32'h0);
        check("rst_empty",    32'(empty),     32'(1'b1));
        check("rst_full",     32'(full),      32'(1'b0));
        check("rst_state",    32'(dbg_state), 32'h0);
`ifdef UART_TX_FIFO_OVF_EN
        check("rst_ovf",      32'(ovf),       32'(1'b0));
`endif

        // ---- table-driven vectors ----
        for (int i = 0; i < 13; i++) begin
            tick(1'b0, vecs[i].wr, vecs[i].data, vecs[i].done);
            check($sformatf("vec%0d_start", i), 32'(tx_start), 32'(vecs[i].exp_start));
            check($sformatf("vec%0d_busy", i),  32'(busy),     32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_level", i), 32'(level),    32'(vecs[i].exp_level));
            check($sformatf("vec%0d_empty", i), 32'(empty),    32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_din", i),   32'(din),      32'(vecs[i].exp_din));
        end

        // ---- fill 16 in WAIT, overflow dropped, drain in order ----
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 8'hEE, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0);            // LOAD of 0xEE
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 8'(i), 1'b0);
        check("fill_full",  32'(full),  32'(1'b1));
        check("fill_level", 32'(level), 32'd16);
        check("fill_busy",  32'(busy),  32'(1'b1));
        tick(1'b0, 1'b1, 8'hAA, 1'b0);            // dropped
        check("drop_level", 32'(level), 32'd16);
        check("drop_full",  32'(full),  32'(1'b1));
        starts0 = n_starts;
        for (int i = 0; i < 16; i++) begin
            finish_frame();
            next_frame();
        end
        finish_frame();
        check("drain_starts", 32'(n_starts - starts0), 32'd16);
        check("drain_empty",  32'(empty), 32'(1'b1));

        // ---- simultaneous write + pop at level 3 across pointer wrap ----
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 13; i++) tick(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        check("wrap_pre_level", 32'(level), 32'd12);
        for (int i = 0; i < 9; i++) begin
            finish_frame();
            next_frame();
        end
        check("wrap_level3", 32'(level), 32'd3);
        for (int k = 0; k < 4; k++) begin
            finish_frame();
            tick(1'b0, 1'b1, 8'(8'hC0 + k), 1'b0); // IDLE pop + write together
            check("wrap_pop_start", 32'(tx_start), 32'(1'b1));
            check("wrap_pop_level", 32'(level),    32'd3);
            tick(1'b0, 1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            finish_frame();
            next_frame();
        end
        finish_frame();
        check("wrap_empty", 32'(empty), 32'(1'b1));

        // ---- reset in WAIT with level 5, reset beats wr/done ----
        tick(1'b0, 1'b1, 8'hD0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        check("rst5_pre_level", 32'(level), 32'd5);
        check("rst5_pre_busy",  32'(busy),  32'(1'b1));
        tick(1'b1, 1'b1, 8'h77, 1'b1);
        check("rst5_level", 32'(level),    32'd0);
        check("rst5_empty", 32'(empty),    32'(1'b1));
        check("rst5_busy",  32'(busy),     32'(1'b0));
        check("rst5_start", 32'(tx_start), 32'(1'b0));
        check("rst5_din",   32'(din),      32'h0);
        tick(1'b0, 1'b0, 8'h00, 1'b1);            // stale done from old frame
        for (int i = 0; i < 3; i++) begin
            check("rst5_no_start", 32'(tx_start), 32'(1'b0));
            check("rst5_idle",     32'(busy),     32'(1'b0));
            tick(1'b0, 1'b0, 8'h00, 1'b0);
        end

`ifdef UART_TX_FIFO_OVF_EN
        // ---- sticky overflow ----
        check("ovf_init", 32'(ovf), 32'(1'b0));
        tick(1'b0, 1'b1, 8'h10, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
        check("ovf_full_no_set", 32'(ovf), 32'(1'b0));
        tick(1'b0, 1'b1, 8'hAA, 1'b0);
        check("ovf_set", 32'(ovf), 32'(1'b1));
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        check("ovf_hold", 32'(ovf), 32'(1'b1));
        ovf_clr = 1'b1;
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        check("ovf_clr", 32'(ovf), 32'(1'b0));
        ovf_clr = 1'b1;
        tick(1'b0, 1'b1, 8'hAB, 1'b0);
        check("ovf_set_wins", 32'(ovf), 32'(1'b1));
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        check("ovf_reset", 32'(ovf), 32'(1'b0));
`endif

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
